// File: rtl/regfile_sb_if.sv
// regfile_sb_if: decode-side alloc handshake and write-back bus for regfile_sb.
interface regfile_sb_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
);
  localparam int unsigned AW = $clog2(NREGS);

  logic            alloc_valid;
  logic [AW-1:0]   alloc_addr;
  logic            alloc_ready;
  logic            wb_valid;
  logic [AW-1:0]   wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            wb_is_load;
  logic [2:0]      wb_funct3;
  logic [2:0]      wb_byte_off;
  logic [XLEN-1:0] mem_data;

  modport master (
    output alloc_valid, alloc_addr, wb_valid, wb_addr, wb_data,
           wb_is_load, wb_funct3, wb_byte_off, mem_data,
    input  alloc_ready
  );

  modport slave (
    input  alloc_valid, alloc_addr, wb_valid, wb_addr, wb_data,
           wb_is_load, wb_funct3, wb_byte_off, mem_data,
    output alloc_ready
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with pending-write scoreboard and load extract/extend on write-back.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle write-back values to the read ports.
module regfile_sb #(
  parameter  int unsigned XLEN  = 32,
  parameter  int unsigned NREGS = 32,
  parameter  int unsigned CNTW  = 6,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  regfile_sb_if.slave     bus,
  input  logic [AW-1:0]   rd_addr1,
  input  logic [AW-1:0]   rd_addr2,
  output logic [XLEN-1:0] rd_data1,
  output logic [XLEN-1:0] rd_data2,
  output logic            rd_busy1,
  output logic            rd_busy2,
  output logic            load_err,
  output logic [CNTW-1:0] pending_cnt
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;

  logic [63:0]      mem64;
  logic [7:0]       ld_b;
  logic [15:0]      ld_h;
  logic [31:0]      ld_w;
  logic [XLEN-1:0]  ld_value;
  logic             load_illegal;
  logic [XLEN-1:0]  wb_value;
  logic             wb_hit;
  logic             wb_write;
  logic             alloc_ready;
  logic             alloc_acc;
  logic             cnt_inc;
  logic             cnt_dec;

  // Padding to 64 bits keeps every slice in range at XLEN=32; offsets that
  // reach the padding are flagged misaligned and never written.
  assign mem64 = 64'(bus.mem_data);
  assign ld_b  = mem64[{bus.wb_byte_off, 3'b000} +: 8];
  assign ld_h  = mem64[{bus.wb_byte_off[2:1], 4'b0000} +: 16];
  assign ld_w  = mem64[{bus.wb_byte_off[2], 5'b00000} +: 32];

  always_comb begin
    load_illegal = 1'b0;
    ld_value     = '0;
    case (bus.wb_funct3)
      3'b000: ld_value = XLEN'($signed(ld_b));
      3'b100: ld_value = XLEN'(ld_b);
      3'b001: begin
        ld_value     = XLEN'($signed(ld_h));
        load_illegal = bus.wb_byte_off[0];
      end
      3'b101: begin
        ld_value     = XLEN'(ld_h);
        load_illegal = bus.wb_byte_off[0];
      end
      3'b010: begin
        ld_value     = XLEN'($signed(ld_w));
        load_illegal = (bus.wb_byte_off[1:0] != 2'b00);
      end
      3'b110: begin
        ld_value     = XLEN'(ld_w);
        load_illegal = (bus.wb_byte_off[1:0] != 2'b00) || (XLEN == 32);
      end
      3'b011: begin
        ld_value     = bus.mem_data;
        load_illegal = (bus.wb_byte_off != 3'b000) || (XLEN == 32);
      end
      default: load_illegal = 1'b1;
    endcase
    if ((XLEN == 32) && bus.wb_byte_off[2])
      load_illegal = 1'b1;
  end

  assign wb_value    = bus.wb_is_load ? ld_value : bus.wb_data;
  assign wb_hit      = bus.wb_valid && (bus.wb_addr != '0);
  assign wb_write    = wb_hit && !(bus.wb_is_load && load_illegal);

  assign alloc_ready     = !busy[bus.alloc_addr] ||
                           (bus.wb_valid && (bus.wb_addr == bus.alloc_addr));
  assign bus.alloc_ready = alloc_ready;
  assign alloc_acc       = bus.alloc_valid && alloc_ready && (bus.alloc_addr != '0);

  // A re-reservation of a register being written back leaves it busy, so
  // neither the increment nor the decrement applies.
  assign cnt_inc = alloc_acc && !busy[bus.alloc_addr];
  assign cnt_dec = wb_hit && busy[bus.wb_addr] &&
                   !(alloc_acc && (bus.alloc_addr == bus.wb_addr));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREGS; i++)
        regs[i] <= '0;
    end else if (wb_write) begin
      regs[bus.wb_addr] <= wb_value;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy        <= '0;
      load_err    <= 1'b0;
      pending_cnt <= '0;
    end else begin
      if (wb_hit)
        busy[bus.wb_addr] <= 1'b0;
      if (alloc_acc)
        busy[bus.alloc_addr] <= 1'b1;
      load_err <= bus.wb_valid && bus.wb_is_load && load_illegal;
      case ({cnt_inc, cnt_dec})
        2'b10:   pending_cnt <= pending_cnt + CNTW'(1);
        2'b01:   pending_cnt <= pending_cnt - CNTW'(1);
        default: pending_cnt <= pending_cnt;
      endcase
    end
  end

  always_comb begin
    rd_data1 = (rd_addr1 == '0) ? '0 : regs[rd_addr1];
    rd_data2 = (rd_addr2 == '0) ? '0 : regs[rd_addr2];
    rd_busy1 = busy[rd_addr1];
    rd_busy2 = busy[rd_addr2];
`ifdef REGFILE_SB_BYPASS_EN
    if (wb_hit && (bus.wb_addr == rd_addr1)) begin
      if (wb_write)
        rd_data1 = wb_value;
      rd_busy1 = alloc_acc && (bus.alloc_addr == rd_addr1);
    end
    if (wb_hit && (bus.wb_addr == rd_addr2)) begin
      if (wb_write)
        rd_data2 = wb_value;
      rd_busy2 = alloc_acc && (bus.alloc_addr == rd_addr2);
    end
`endif
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised integer register file for the RISC-V core, with a per-register pending-write scoreboard and an aligned load-extract/extend unit on the write-back path.
- Decode reserves a destination through the alloc port; write-back (ALU result or memory load) fills it and clears the reservation.
- Read ports report data plus a busy flag, which the hazard unit uses to stall.

Parameters:
- XLEN, 32, register width; legal values 32 or 64.
- NREGS, 32, number of architectural registers; power of two, 2..32. AW = $clog2(NREGS) is a localparam.
- CNTW, 6, width of the pending-count output; must satisfy 2^CNTW > NREGS.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- rd_addr1  in  AW  read port 1 address
- rd_addr2  in  AW  read port 2 address
- rd_data1  out  XLEN  read port 1 data
- rd_data2  out  XLEN  read port 2 data
- rd_busy1  out  1  rd_addr1 has a pending write
- rd_busy2  out  1  rd_addr2 has a pending write
- alloc_valid  in  1  reserve destination alloc_addr
- alloc_addr  in  AW  destination to reserve
- alloc_ready  out  1  reservation can be accepted this cycle
- wb_valid  in  1  write-back strobe
- wb_addr  in  AW  write-back destination
- wb_data  in  XLEN  ALU result, used when wb_is_load=0
- wb_is_load  in  1  write-back source is memory
- wb_funct3  in  3  load type: LB 000, LH 001, LW 010, LD 011, LBU 100, LHU 101, LWU 110
- wb_byte_off  in  3  load address bits [2:0]
- mem_data  in  XLEN  aligned memory word (doubleword when XLEN=64)
- load_err  out  1  registered pulse: illegal or misaligned load dropped
- pending_cnt  out  CNTW  number of busy registers

Behaviour:
- Reset (asynchronous): all registers = 0, all busy bits = 0, load_err = 0, pending_cnt = 0. No preloaded values.
- Register 0: always reads 0, is never busy, and ignores writes. alloc_addr=0 is accepted as a no-op.
- Reads are combinational:
  - rd_data = reg[addr]; rd_busy = busy[addr].
  - With the bypass feature off, a write in cycle N is visible to reads in cycle N+1.
- alloc_ready = !busy[alloc_addr] || (wb_valid && wb_addr == alloc_addr).
  - Accepted when alloc_valid && alloc_ready: busy[alloc_addr] is set at the next edge.
  - alloc_valid while alloc_ready=0 is ignored; decode must hold and retry.
- Write-back when wb_valid && wb_addr != 0 (and the load is legal): reg updated and busy cleared at the next edge.
  - Write-back to a non-busy register is legal: the write happens and busy stays 0.
- Same cycle, same address, alloc accepted and write-back: data is written and busy ends as 1 (the new reservation wins).
- Load extraction with wb_byte_off = o:
  - Byte: mem_data[8*o +: 8].
  - Half: mem_data[16*o[2:1] +: 16]; requires o[0]=0.
  - Word: mem_data[32*o[2] +: 32]; requires o[1:0]=0.
  - LD: whole word; requires o=0.
  - When XLEN=32, o[2] must be 0 for all loads; nonzero o[2] is misaligned.
- Load extension:
  - LB/LH/LW sign-extend to XLEN.
  - LBU/LHU/LWU zero-extend.
  - LW at XLEN=32 is an identity copy.
- Illegal load: funct3 111; or 011/110 when XLEN=32; or any misaligned offset.
  - Register is not written and busy is still cleared.
  - load_err = 1 for exactly the next cycle, else 0.
- pending_cnt is registered: +1 per busy bit set, -1 per busy bit cleared, net 0 when both happen on the same cycle. It always equals popcount(busy).
- Reset asserted mid-operation clears all state immediately. Inputs are ignored while reset is high.

Optional Feature:
- Macro: REGFILE_SB_BYPASS_EN.
- Defined: a write-back in cycle N forwards its final extended value to any read port with a matching nonzero address in the same cycle. The matching rd_busy reads 0, unless a same-cycle alloc to that address is accepted, in which case it reads 1.
- Undefined: no forwarding; reads return the stored value and current busy bit only.

Test Plan:
- Reset, then read x0..x31 -> all data 0, busy 0, pending_cnt=0. Write x0=0xDEADBEEF -> x0 still reads 0.
- Alloc x5 -> busy[5]=1, pending_cnt=1. Second alloc x5 -> alloc_ready=0, ignored. Write-back x5=0x1234 -> x5=0x00001234, busy 0, pending_cnt=0.
- mem_data=0x80F17F02 (XLEN=32):
  - LB o=3 -> 0xFFFFFF80
  - LBU o=1 -> 0x0000007F
  - LH o=2 -> 0xFFFF80F1
  - LHU o=0 -> 0x00007F02
- LH o=1, and LD at XLEN=32 -> register unchanged, busy cleared, load_err high exactly 1 cycle.
- Same cycle: alloc x7 and write-back x7=0x14 -> x7=0x14, busy[7]=1, pending_cnt unchanged.
- With bypass: write-back x3=0xA5 while rd_addr1=3 -> rd_data1=0xA5 same cycle. Without bypass: old value that cycle, 0xA5 the next.
